// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Shares the single register-file write port among NUM_REQ write-back
// requesters (ALU, load unit, multiplier, ...). Arbitration is round-robin
// with a valid/ready handshake, and the winning write appears on the
// register-file port one cycle after acceptance. A per-register pending
// scoreboard lets the issue stage stall on operands whose write-back has
// not yet committed.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   resetn     : asynchronous active-low reset
//   req_valid  : per-requester write request
//   req_addr   : flattened destination addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data   : flattened write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  : one-hot grant (combinational), forced low during reset
//   rf_wen     : register-file write enable (registered)
//   rf_waddr   : register-file write address (registered)
//   rf_wdata   : register-file write data (registered)
//   rf_src     : index of the requester whose write is on the port (registered)
//   sb_set     : issue stage marks sb_addr as pending
//   sb_addr    : destination register being issued
//   chk_a1/2   : operand addresses to check
//   busy1/2    : pending state of chk_a1/chk_a2 (combinational)
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 3
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            rf_wen,
    output logic [ADDR_WIDTH-1:0]           rf_waddr,
    output logic [DATA_WIDTH-1:0]           rf_wdata,
    output logic [$clog2(NUM_REQ)-1:0]      rf_src,
    input  logic                            sb_set,
    input  logic [ADDR_WIDTH-1:0]           sb_addr,
    input  logic [ADDR_WIDTH-1:0]           chk_a1,
    input  logic [ADDR_WIDTH-1:0]           chk_a2,
    output logic                            busy1,
    output logic                            busy2
);

    localparam int SRC_WIDTH = $clog2(NUM_REQ);
    localparam int SUM_WIDTH = SRC_WIDTH + 1;
    localparam int NUM_REGS  = 2 ** ADDR_WIDTH;

    logic [SRC_WIDTH-1:0]  rr_r;
    logic [NUM_REQ-1:0]    grant_s;
    logic                  xfer_s;
    logic [SRC_WIDTH-1:0]  gnt_idx_s;
    logic [ADDR_WIDTH-1:0] gnt_addr_s;
    logic [DATA_WIDTH-1:0] gnt_data_s;

    logic                  rf_wen_r;
    logic [ADDR_WIDTH-1:0] rf_waddr_r;
    logic [DATA_WIDTH-1:0] rf_wdata_r;
    logic [SRC_WIDTH-1:0]  rf_src_r;

    logic [NUM_REGS-1:0]   pending_r;
    logic [NUM_REGS-1:0]   set_s;
    logic [NUM_REGS-1:0]   clr_s;

    // Round-robin scan starting at rr_r: the first valid requester wins.
    always_comb begin
        logic [SUM_WIDTH-1:0] sum_v;
        logic [SRC_WIDTH-1:0] idx_v;
        logic                 found_v;
        grant_s = '0;
        found_v = 1'b0;
        sum_v   = '0;
        idx_v   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // rr_r < NUM_REQ and k < NUM_REQ, so one subtraction wraps the sum.
            sum_v = {1'b0, rr_r} + SUM_WIDTH'(k);
            if (sum_v >= SUM_WIDTH'(NUM_REQ)) begin
                sum_v = sum_v - SUM_WIDTH'(NUM_REQ);
            end else begin
                sum_v = sum_v;
            end
            idx_v          = sum_v[SRC_WIDTH-1:0];
            grant_s[idx_v] = grant_s[idx_v] | (req_valid[idx_v] & ~found_v);
            found_v        = found_v | req_valid[idx_v];
        end
    end

    // One-hot AND-OR mux selecting the winner's index, address and data.
    always_comb begin
        gnt_idx_s  = '0;
        gnt_addr_s = '0;
        gnt_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_idx_s  = gnt_idx_s  | (SRC_WIDTH'(i) & {SRC_WIDTH{grant_s[i]}});
            gnt_addr_s = gnt_addr_s | (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{grant_s[i]}});
            gnt_data_s = gnt_data_s | (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_s[i]}});
        end
    end

    assign xfer_s    = |grant_s;
    assign req_ready = grant_s & {NUM_REQ{resetn}};

    // Round-robin pointer: moves just past the requester that was served.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_r <= '0;
        end else if (xfer_s) begin
            rr_r <= (gnt_idx_s == SRC_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx_s + SRC_WIDTH'(1);
        end else begin
            rr_r <= rr_r;
        end
    end

    // Output stage: accepted write appears on the port one cycle later.
    // Writes to register 0 are accepted but never enable the register file.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rf_wen_r   <= 1'b0;
            rf_waddr_r <= '0;
            rf_wdata_r <= '0;
            rf_src_r   <= '0;
        end else if (xfer_s) begin
            rf_wen_r   <= (gnt_addr_s != '0);
            rf_waddr_r <= gnt_addr_s;
            rf_wdata_r <= gnt_data_s;
            rf_src_r   <= gnt_idx_s;
        end else begin
            rf_wen_r   <= 1'b0;
            rf_waddr_r <= rf_waddr_r;
            rf_wdata_r <= rf_wdata_r;
            rf_src_r   <= rf_src_r;
        end
    end

    // Per-register set/clear decode; register 0 can never become pending.
    always_comb begin
        set_s = '0;
        clr_s = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            set_s[r] = sb_set & (sb_addr != '0) & (sb_addr == ADDR_WIDTH'(r));
            clr_s[r] = rf_wen_r & (rf_waddr_r == ADDR_WIDTH'(r));
        end
    end

    // Scoreboard: clear on the committing edge, but a same-edge set wins
    // because it belongs to a newer producer of that register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_r <= '0;
        end else begin
            pending_r <= (pending_r & ~clr_s) | set_s;
        end
    end

    assign busy1 = pending_r[chk_a1] & (chk_a1 != '0);
    assign busy2 = pending_r[chk_a2] & (chk_a2 != '0);

    assign rf_wen   = rf_wen_r;
    assign rf_waddr = rf_waddr_r;
    assign rf_wdata = rf_wdata_r;
    assign rf_src   = rf_src_r;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter
//
// Self-checking bench for rf_wb_arbiter: reset behaviour, a table of
// directed vectors with hand-derived expectations, a mid-transfer reset,
// and a randomized phase. A behavioural model (round-robin by modular
// arithmetic, a pending-bit array, and the accepted write) predicts every
// output each cycle.
// -----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int N  = 3;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              resetn;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              rf_wen;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;
    logic [SW-1:0]     rf_src;
    logic              sb_set;
    logic [AW-1:0]     sb_addr;
    logic [AW-1:0]     chk_a1;
    logic [AW-1:0]     chk_a2;
    logic              busy1;
    logic              busy2;

    int tests = 0;
    int fails = 0;

    rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_src(rf_src),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .chk_a1(chk_a1), .chk_a2(chk_a2),
        .busy1(busy1), .busy2(busy2)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int            m_rr;
    bit            m_pend [32];
    bit            m_wen;
    int            m_waddr;
    logic [DW-1:0] m_wdata;
    int            m_src;
    int            m_g;
    int            m_last_g;
    int            m_wait [N];

    typedef struct packed {
        logic [N-1:0]    valid;
        logic [N*AW-1:0] addr;
        logic [N*DW-1:0] data;
        logic            ss;
        logic [AW-1:0]   sa;
        logic [AW-1:0]   ck;
        logic [N-1:0]    er;
        logic            ew;
        logic [AW-1:0]   ewa;
        logic            eb;
    } vec_t;

    vec_t tbl [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_wen = 1'b0; m_waddr = 0; m_wdata = '0; m_src = 0;
        m_g = -1; m_last_g = -1;
        for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
    endtask

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // Called at the negative edge: compare every output with the model.
    task automatic check_model();
        logic [N-1:0] eg;
        m_g = model_grant();
        eg  = '0;
        if (resetn && m_g >= 0) eg[m_g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(eg));
        check("rf_wen",    64'(rf_wen),    64'(m_wen));
        check("rf_waddr",  64'(rf_waddr),  64'(m_waddr));
        check("rf_wdata",  64'(rf_wdata),  64'(m_wdata));
        check("rf_src",    64'(rf_src),    64'(m_src));
        check("busy1", 64'(busy1), 64'((chk_a1 != 0) && m_pend[chk_a1]));
        check("busy2", 64'(busy2), 64'((chk_a2 != 0) && m_pend[chk_a2]));
    endtask

    // Advance the model across the next rising edge, then settle 1 time unit.
    task automatic advance();
        logic [AW-1:0] a;
        @(posedge clk);
        if (resetn) begin
            if (m_wen) m_pend[m_waddr] = 1'b0;
            if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
            if (m_g >= 0) begin
                a       = req_addr[m_g*AW +: AW];
                m_rr    = (m_g + 1) % N;
                m_wen   = (a != 0);
                m_waddr = int'(a);
                m_wdata = req_data[m_g*DW +: DW];
                m_src   = m_g;
            end else begin
                m_wen = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && m_g != i) begin
                    m_wait[i]++;
                    check("fairness_wait", 64'(m_wait[i] < N), 64'd1);
                end else begin
                    m_wait[i] = 0;
                end
            end
            m_last_g = m_g;
        end else begin
            m_last_g = -1;
        end
        #1;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_model();
        advance();
    endtask

    function automatic vec_t mk(input logic [2:0] v,
                                input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input logic ss, input logic [4:0] sa, input logic [4:0] ck,
                                input logic [2:0] er, input logic ew, input logic [4:0] ewa, input logic eb);
        vec_t t;
        t.valid = v;
        t.addr  = {a2, a1, a0};
        t.data  = {d2, d1, d0};
        t.ss = ss; t.sa = sa; t.ck = ck;
        t.er = er; t.ew = ew; t.ewa = ewa; t.eb = eb;
        return t;
    endfunction

    initial begin
        // ---- directed table (starts right after reset release) ----
        // All three requesters: strict rotation 0,1,2,0,1,2.
        for (int r = 0; r < 6; r++) begin
            logic [2:0] er;
            er = 3'b001 << (r % 3);
            tbl.push_back(mk(3'b111, 5'd5, 5'd6, 5'd7, 32'hA, 32'hB, 32'hC, 1'b0, 5'd0, 5'd0,
                             er, (r != 0), (r == 0) ? 5'd0 : 5'(5 + ((r - 1) % 3)), 1'b0));
        end
        tbl.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 3'b000, 1'b1, 5'd7, 1'b0));
        // Lone req 2, then req 0 and 1 together.
        tbl.push_back(mk(3'b100, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 3'b100, 1'b0, 5'd7, 1'b0));
        tbl.push_back(mk(3'b011, 5'd3, 5'd4, 5'd0, 32'h33, 32'h44, 32'h0, 1'b0, 5'd0, 5'd0, 3'b001, 1'b1, 5'd9, 1'b0));
        tbl.push_back(mk(3'b010, 5'd0, 5'd4, 5'd0, 32'h0, 32'h44, 32'h0, 1'b0, 5'd0, 5'd0, 3'b010, 1'b1, 5'd3, 1'b0));
        tbl.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 3'b000, 1'b1, 5'd4, 1'b0));
        // Scoreboard set on 12, then commit via req 1.
        tbl.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd12, 5'd12, 3'b000, 1'b0, 5'd4, 1'b0));
        tbl.push_back(mk(3'b010, 5'd0, 5'd12, 5'd0, 32'h0, 32'h1212, 32'h0, 1'b0, 5'd0, 5'd12, 3'b010, 1'b0, 5'd4, 1'b1));
        tbl.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd12, 3'b000, 1'b1, 5'd12, 1'b1));
        tbl.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd12, 3'b000, 1'b0, 5'd12, 1'b0));
        // Set and commit of 12 on the same edge: set wins.
        tbl.push_back(mk(3'b010, 5'd0, 5'd12, 5'd0, 32'h0, 32'h1313, 32'h0, 1'b1, 5'd12, 5'd12, 3'b010, 1'b0, 5'd12, 1'b0));
        tbl.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd12, 5'd12, 3'b000, 1'b1, 5'd12, 1'b1));
        tbl.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd12, 3'b000, 1'b0, 5'd12, 1'b1));
        // Commit of 12 with set of 13 on the same edge: both take effect.
        tbl.push_back(mk(3'b010, 5'd0, 5'd12, 5'd0, 32'h0, 32'h1414, 32'h0, 1'b0, 5'd0, 5'd12, 3'b010, 1'b0, 5'd12, 1'b1));
        tbl.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd13, 5'd12, 3'b000, 1'b1, 5'd12, 1'b1));
        tbl.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd12, 3'b000, 1'b0, 5'd12, 1'b0));
        tbl.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd13, 3'b000, 1'b0, 5'd12, 1'b1));
        // Register 0: accepted, pointer advances, no write enable; sb_set 0 ignored.
        tbl.push_back(mk(3'b001, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 5'd0, 5'd0, 3'b001, 1'b0, 5'd12, 1'b0));
        tbl.push_back(mk(3'b011, 5'd2, 5'd1, 5'd0, 32'h2, 32'h1, 32'h0, 1'b0, 5'd0, 5'd0, 3'b010, 1'b0, 5'd0, 1'b0));
        tbl.push_back(mk(3'b001, 5'd2, 5'd0, 5'd0, 32'h2, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 3'b001, 1'b1, 5'd1, 1'b0));
        tbl.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 3'b000, 1'b1, 5'd2, 1'b0));

        // ---- reset with all requesters valid ----
        resetn    = 1'b0;
        req_valid = 3'b111;
        req_addr  = {5'd7, 5'd6, 5'd5};
        req_data  = {32'hC, 32'hB, 32'hA};
        sb_set = 1'b0; sb_addr = '0; chk_a1 = '0; chk_a2 = 5'd13;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("reset_ready", 64'(req_ready), 64'd0);
            check("reset_wen",   64'(rf_wen),    64'd0);
        end
        @(posedge clk);
        #1 resetn = 1'b1;

        // ---- apply table ----
        foreach (tbl[r]) begin
            req_valid = tbl[r].valid;
            req_addr  = tbl[r].addr;
            req_data  = tbl[r].data;
            sb_set    = tbl[r].ss;
            sb_addr   = tbl[r].sa;
            chk_a1    = tbl[r].ck;
            chk_a2    = 5'd13;
            @(negedge clk);
            check($sformatf("tbl%0d_ready", r), 64'(req_ready), 64'(tbl[r].er));
            check($sformatf("tbl%0d_wen", r),   64'(rf_wen),    64'(tbl[r].ew));
            check($sformatf("tbl%0d_waddr", r), 64'(rf_waddr),  64'(tbl[r].ewa));
            check($sformatf("tbl%0d_busy1", r), 64'(busy1),     64'(tbl[r].eb));
            check_model();
            advance();
        end

        // ---- reset in the middle of a transfer ----
        set_req(0, 1'b1, 5'd7, 32'h77);
        set_req(1, 1'b0, 5'd0, 32'h0);
        set_req(2, 1'b0, 5'd0, 32'h0);
        sb_set = 1'b1; sb_addr = 5'd7; chk_a1 = 5'd7;
        cycle();
        sb_set = 1'b0;
        check("pre_rst_wen", 64'(rf_wen), 64'd1);
        #2 resetn = 1'b0;
        #1;
        check("midrst_wen",   64'(rf_wen),    64'd0);
        check("midrst_ready", 64'(req_ready), 64'd0);
        check("midrst_busy",  64'(busy1),     64'd0);
        model_reset();
        cycle();
        resetn = 1'b1;
        set_req(0, 1'b0, 5'd0, 32'h0);
        cycle();
        cycle();

        // ---- randomized phase, requesters hold until accepted ----
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || m_last_g == i) begin
                    if ($urandom_range(0, 3) != 0)
                        set_req(i, 1'b1, AW'($urandom_range(0, 7)), $urandom);
                    else
                        set_req(i, 1'b0, 5'd0, 32'h0);
                end
            end
            sb_set  = ($urandom_range(0, 2) == 0);
            sb_addr = AW'($urandom_range(0, 7));
            chk_a1  = AW'($urandom_range(0, 7));
            chk_a2  = AW'($urandom_range(0, 7));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
